freelist: RTL

FREELIST -- requirements
Module: freelist

---
 rtl/sys_defs.sv | 18 +
 rtl/freelist.sv | 99 +++++++++
 2 files changed

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared rename definitions: physical register and free-list sizing
package sys_defs;

    localparam int PHYS_REG_W = 6;
    typedef logic [PHYS_REG_W-1:0] phys_reg_t;

    // Architectural zero maps to this register; it is never allocated or freed.
    localparam phys_reg_t PHYS_ZERO_REG = 6'd63;

    // Free-list geometry; pointers carry one extra wrap bit.
    localparam int FL_DEPTH = 32;
    localparam int FL_PTR   = $clog2(FL_DEPTH) + 1;
    typedef logic [FL_PTR-1:0] fl_ptr_t;

    // Registers 0..31 hold the initial architectural mappings, so the list starts at 32.
    localparam int FL_RESET_BASE = 32;

endpackage

// File: rtl/freelist.sv
// rtl/freelist.sv - physical register free list: two-wide allocate, two-wide retire, head rollback
module freelist
    import sys_defs::*;
#(
    parameter int FL_DEPTH = sys_defs::FL_DEPTH,
    localparam int PTR_W = $clog2(FL_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        dispatch_num,
    input  logic [1:0]        retire_en,
    input  phys_reg_t         retire_idx [0:1],
    input  logic              recover_en,
    input  logic [PTR_W-1:0]  recover_head,
    output phys_reg_t         free_idx [0:1],
    output logic [1:0]        free_valid,
    output logic [PTR_W-1:0]  num_free,
    output logic [PTR_W-1:0]  head_out
);

    localparam int IDX_W = PTR_W - 1;
    typedef logic [PTR_W-1:0] ptr_t;

    phys_reg_t        entries_q [FL_DEPTH];
    phys_reg_t        entries_d [FL_DEPTH];
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;

    ptr_t             occ;
    ptr_t             space;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] head_idx1;
    logic [1:0]       req;
    logic [1:0]       grant;
    logic [1:0]       n_push;
    logic [1:0]       way_ok;
    logic [IDX_W-1:0] wr_idx;

    // Occupancy and the two-entry lookahead window, all from pre-edge state.
    always_comb begin
        occ           = tail_q - head_q;
        head_idx      = head_q[IDX_W-1:0];
        head_idx1     = head_idx + IDX_W'(1);
        free_idx[0]   = entries_q[head_idx];
        free_idx[1]   = entries_q[head_idx1];
        free_valid[0] = (occ != '0);
        free_valid[1] = (occ > ptr_t'(1));
        num_free      = occ;
        head_out      = head_q;
    end

    // Allocation: grant is the request clamped to what is free; a rollback cancels it.
    always_comb begin
        req   = (dispatch_num > 2'd2) ? 2'd2 : dispatch_num;
        grant = 2'd0;
        if (!recover_en) begin
            if (ptr_t'(req) > occ) begin
                grant = occ[1:0];
            end else begin
                grant = req;
            end
        end
        head_d = recover_en ? recover_head : (head_q + ptr_t'(grant));
    end

    // Retire: compact the surviving ways onto the tail, way 0 first, never overfilling.
    always_comb begin
        way_ok[0] = retire_en[0] && (retire_idx[0] != PHYS_ZERO_REG);
        way_ok[1] = retire_en[1] && (retire_idx[1] != PHYS_ZERO_REG);
        space     = ptr_t'(FL_DEPTH) - occ;
        entries_d = entries_q;
        n_push    = 2'd0;
        wr_idx    = '0;
        for (int w = 0; w < 2; w++) begin
            if (way_ok[w] && (ptr_t'(n_push) < space)) begin
                wr_idx            = tail_q[IDX_W-1:0] + IDX_W'(n_push);
                entries_d[wr_idx] = retire_idx[w];
                n_push            = n_push + 2'd1;
            end
        end
        tail_d = tail_q + ptr_t'(n_push);
    end

    // State update; reset seeds the list with every non-architectural register except zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                entries_q[k] <= (k < FL_DEPTH - 1) ? phys_reg_t'(FL_RESET_BASE + k) : '0;
            end
            head_q <= '0;
            tail_q <= ptr_t'(FL_DEPTH - 1);
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

endmodule
